// File: rtl/approx_mul_pkg.sv
// Shared types and elaboration helpers for the approx_mul_pipe multiplier.
package approx_mul_pkg;

    localparam int MAX_W  = 32;
    localparam int MAX_ZW = 2 * MAX_W;

    function automatic int zw(input int w);
        return 2 * w;
    endfunction

    function automatic bit params_ok(input int w, input int l, input int k);
        return (w >= 4) && (w <= MAX_W) &&
               (l >= 0) && (l <= w - 1) &&
               (k >= 1) && (k <= w + l - 1);
    endfunction

    // Sized for the widest legal W; each stage fills only the fields it uses.
    typedef struct packed {
        logic [MAX_W-1:0]  x;
        logic [MAX_W-1:0]  y;
        logic              exact;
        logic [MAX_ZW-1:0] hi;
        logic [MAX_ZW-1:0] cols;
        logic              comp;
    } stage_t;

endpackage

// File: rtl/approx_pp_compress.sv
// Column-OR compression of the low L partial-product rows at and above column K.
// The compensation bit p exists only when APPROX_MUL_COMP_EN is defined.
module approx_pp_compress
    import approx_mul_pkg::*;
#(
    parameter int W = 8,
    parameter int L = 2,
    parameter int K = 7
) (
    input  logic [((L > 0) ? L : 1)-1:0] x_lo,
    input  logic [W-1:0]                 y,
    output logic [zw(W)-1:0]             o,
    output logic                         p
);

    always_comb begin
        // NOTE: default every combinational output first so no path can infer a latch.
        o = '0;
        for (int c = K; c < zw(W); c++) begin
            for (int i = 0; i < L; i++) begin
                if ((c - i >= 0) && (c - i < W)) begin
                    o[c] = o[c] | (x_lo[i] & y[c - i]);
                end
            end
        end
    end

`ifdef APPROX_MUL_COMP_EN
    // p stands in for the carries lost by truncating column K-1.
    always_comb begin
        p = 1'b0;
        for (int i = 0; i < L; i++) begin
            if ((K - 1 - i >= 0) && (K - 1 - i < W)) begin
                p = p | (x_lo[i] & y[K - 1 - i]);
            end
        end
    end
`else
    assign p = 1'b0;
`endif

endmodule

// File: rtl/approx_mul_pipe.sv
// Three-stage streaming approximate/exact unsigned multiplier with valid/ready backpressure.
// Optional compensation bit controlled by macro APPROX_MUL_COMP_EN.
module approx_mul_pipe
    import approx_mul_pkg::*;
#(
    parameter int W = 8,
    parameter int L = 2,
    parameter int K = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_x,
    input  logic [W-1:0]        in_y,
    input  logic                in_exact,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [zw(W)-1:0]    out_z,
    output logic                out_exact
);

    localparam int ZW = zw(W);
    localparam int LX = (L > 0) ? L : 1;

    if (!params_ok(W, L, K)) begin : g_bad_params
        $error("approx_mul_pipe: illegal parameter set W=%0d L=%0d K=%0d", W, L, K);
    end

    stage_t          s1_q, s1_d;
    stage_t          s2_q, s2_d;
    logic            s1_valid, s2_valid, s3_valid;
    logic            adv;
    logic [W-1:0]    x_w, y_w;
    logic [ZW-1:0]   prod, h_part, cols, sum;
    logic            comp;
    logic [ZW-1:0]   z_q;
    logic            exact_q;

    // Only a held result blocks the pipe; bubbles are never collapsed.
    assign adv       = !(s3_valid && !out_ready);
    assign in_ready  = adv;
    assign out_valid = s3_valid;
    assign out_z     = z_q;
    assign out_exact = exact_q;

    always_comb begin
        s1_d       = '0;
        s1_d.x     = MAX_W'(in_x);
        s1_d.y     = MAX_W'(in_y);
        s1_d.exact = in_exact;
    end

    assign x_w    = s1_q.x[W-1:0];
    assign y_w    = s1_q.y[W-1:0];
    assign prod   = ZW'(x_w) * ZW'(y_w);
    assign h_part = (ZW'(y_w) * ZW'(x_w >> L)) << L;

    approx_pp_compress #(
        .W (W),
        .L (L),
        .K (K)
    ) u_compress (
        .x_lo (x_w[LX-1:0]),
        .y    (y_w),
        .o    (cols),
        .p    (comp)
    );

    always_comb begin
        s2_d       = '0;
        s2_d.exact = s1_q.exact;
        if (s1_q.exact) begin
            s2_d.hi = MAX_ZW'(prod);
        end else begin
            s2_d.hi   = MAX_ZW'(h_part);
            s2_d.cols = MAX_ZW'(cols);
            s2_d.comp = comp;
        end
    end

`ifdef APPROX_MUL_COMP_EN
    assign sum = s2_q.hi[ZW-1:0] + s2_q.cols[ZW-1:0] + (ZW'(s2_q.comp) << K);
`else
    assign sum = s2_q.hi[ZW-1:0] + s2_q.cols[ZW-1:0];
`endif

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    // NOTE: payload registers carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            s1_q <= s1_d;
        end
        if (adv && s1_valid) begin
            s2_q <= s2_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q     <= '0;
            exact_q <= 1'b0;
        end else if (adv && s2_valid) begin
            z_q     <= sum;
            exact_q <= s2_q.exact;
        end
    end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Self-checking bench for approx_mul_pipe: three parameterisations against a partial-product model.
module tb_approx_mul_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // W=8, L=2, K=7
    logic        a_in_valid, a_in_ready, a_exact, a_out_valid, a_out_ready, a_out_exact;
    logic [7:0]  a_x, a_y;
    logic [15:0] a_z;
    // W=16, L=0, K=7
    logic        b_in_valid, b_in_ready, b_exact, b_out_valid, b_out_ready, b_out_exact;
    logic [15:0] b_x, b_y;
    logic [31:0] b_z;
    // W=4, L=3, K=6
    logic        c_in_valid, c_in_ready, c_exact, c_out_valid, c_out_ready, c_out_exact;
    logic [3:0]  c_x, c_y;
    logic [7:0]  c_z;

    approx_mul_pipe #(.W(8), .L(2), .K(7)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_x(a_x), .in_y(a_y), .in_exact(a_exact), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_z(a_z), .out_exact(a_out_exact)
    );

    approx_mul_pipe #(.W(16), .L(0), .K(7)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_x(b_x), .in_y(b_y), .in_exact(b_exact), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_z(b_z), .out_exact(b_out_exact)
    );

    approx_mul_pipe #(.W(4), .L(3), .K(6)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_x(c_x), .in_y(c_y), .in_exact(c_exact), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_z(c_z), .out_exact(c_out_exact)
    );

    // Reference: walk every partial product; high rows add exactly, low rows
    // collapse into per-column ORs or feed the compensation bit.
    function automatic longint unsigned model(input int w, input int l, input int k,
                                              input longint unsigned x, input longint unsigned y,
                                              input bit exact);
        longint unsigned z    = 0;
        longint unsigned cols = 0;
        bit              p    = 1'b0;
        if (exact) return x * y;
        for (int i = 0; i < w; i++) begin
            for (int j = 0; j < w; j++) begin
                if (x[i] && y[j]) begin
                    if (i >= l)               z += 64'd1 << (i + j);
                    else if (i + j >= k)      cols |= 64'd1 << (i + j);
                    else if (i + j == k - 1)  p = 1'b1;
                end
            end
        end
        z += cols;
`ifdef APPROX_MUL_COMP_EN
        if (p) z += 64'd1 << k;
`endif
        return z;
    endfunction

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
        n_checks++; if (a_z !== 16'd0) begin n_fail++; $display("FAIL reset_out_z: got %0d expected 0", a_z); end
        n_checks++; if (a_out_exact !== 1'b0) begin n_fail++; $display("FAIL reset_out_exact: got %b expected 0", a_out_exact); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
        repeat (2) @(negedge clk);
        n_checks++; if (b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_other_valid: got %b/%b expected 0/0", b_out_valid, c_out_valid); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0]      xs [6] = '{8'hFF, 8'hFF, 8'h03, 8'h03, 8'h03, 8'hA5};
        logic [7:0]      ys [6] = '{8'hFF, 8'hFF, 8'h80, 8'h01, 8'h01, 8'h3C};
        bit              es [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        longint unsigned exp_z [6];
        int              lat;
`ifdef APPROX_MUL_COMP_EN
        exp_z[0] = 64772;
`else
        exp_z[0] = 64644;
`endif
        exp_z[1] = 65025;
        exp_z[2] = 384;
        exp_z[3] = 0;
        exp_z[4] = 3;
        exp_z[5] = model(8, 2, 7, 64'hA5, 64'h3C, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a_x = xs[i]; a_y = ys[i]; a_exact = es[i];
            a_in_valid = 1'b1; a_out_ready = 1'b1;
            #1;
            n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL directed_in_ready[%0d]: got %b expected 1", i, a_in_ready); end
            @(posedge clk);
            #1 a_in_valid = 1'b0;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!a_out_valid && lat < 8);
            n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected 3", i, lat); end
            n_checks++; if (a_z !== exp_z[i]) begin n_fail++; $display("FAIL directed_z[%0d]: got %0d expected %0d", i, a_z, exp_z[i]); end
            n_checks++; if (a_out_exact !== es[i]) begin n_fail++; $display("FAIL directed_exact[%0d]: got %b expected %b", i, a_out_exact, es[i]); end
        end
    endtask

    task automatic test_back_to_back();
        longint unsigned exp_z [$];
        bit              exp_e [$];
        int              sent = 0, got = 0, cyc = 0;
        bit              pending = 1'b0, prev_stall = 1'b0;
        logic [15:0]     prev_z = '0;
        logic            prev_e = 1'b0;
        while (got < 16 && cyc < 300) begin
            @(negedge clk);
            if (prev_stall) begin
                n_checks++;
                if (a_out_valid !== 1'b1 || a_z !== prev_z || a_out_exact !== prev_e) begin
                    n_fail++;
                    $display("FAIL b2b_hold: got v=%b z=%0d e=%b expected v=1 z=%0d e=%b", a_out_valid, a_z, a_out_exact, prev_z, prev_e);
                end
            end
            if (!pending && sent < 16) begin
                a_x = 8'($urandom); a_y = 8'($urandom); a_exact = 1'($urandom);
                pending = 1'b1;
            end
            a_in_valid  = pending;
            a_out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            #1;
            n_checks++;
            if (a_in_ready !== !(a_out_valid && !a_out_ready)) begin
                n_fail++;
                $display("FAIL b2b_in_ready: cycle %0d got %b with out_valid=%b out_ready=%b", cyc, a_in_ready, a_out_valid, a_out_ready);
            end
            if (a_in_valid && a_in_ready) begin
                exp_z.push_back(model(8, 2, 7, 64'(a_x), 64'(a_y), a_exact));
                exp_e.push_back(a_exact);
                pending = 1'b0;
                sent++;
            end
            if (a_out_valid && a_out_ready) begin
                n_checks++;
                if (exp_z.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra_beat: got z=%0d expected no beat", a_z);
                end else begin
                    if (a_z !== exp_z[0] || a_out_exact !== exp_e[0]) begin
                        n_fail++; $display("FAIL b2b_result[%0d]: got z=%0d e=%b expected z=%0d e=%b", got, a_z, a_out_exact, exp_z[0], exp_e[0]);
                    end
                    void'(exp_z.pop_front());
                    void'(exp_e.pop_front());
                end
                got++;
            end
            prev_stall = a_out_valid && !a_out_ready;
            prev_z     = a_z;
            prev_e     = a_out_exact;
            cyc++;
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        n_checks++; if (got !== 16) begin n_fail++; $display("FAIL b2b_count: got %0d expected 16", got); end
    endtask

    task automatic test_reset_midstream();
        int              stale = 0;
        int              lat;
        longint unsigned exp;
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_x = 8'($urandom); a_y = 8'($urandom); a_exact = 1'($urandom);
            a_in_valid = 1'b1;
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_inflight: got out_valid=%b expected 1", a_out_valid); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", a_out_valid); end
        n_checks++; if (a_z !== 16'd0) begin n_fail++; $display("FAIL midrst_out_z: got %0d expected 0", a_z); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", a_in_ready); end
        @(negedge clk);
        rst = 1'b0;
        a_out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (a_out_valid) stale++;
        end
        n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL midrst_stale: got %0d beats expected 0", stale); end
        @(negedge clk);
        a_x = 8'hC3; a_y = 8'h7E; a_exact = 1'b0; a_in_valid = 1'b1;
        exp = model(8, 2, 7, 64'hC3, 64'h7E, 1'b0);
        @(posedge clk);
        #1 a_in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!a_out_valid && lat < 8);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL midrst_latency: got %0d expected 3", lat); end
        n_checks++; if (a_z !== exp) begin n_fail++; $display("FAIL midrst_z: got %0d expected %0d", a_z, exp); end
    endtask

    task automatic test_exact_path();
        longint unsigned exp_z [$];
        bit              exp_e [$];
        longint unsigned lx, ly;
        int              sent = 0, got = 0, cyc = 0;
        bit              pending = 1'b0;
        while (got < 1000 && cyc < 8000) begin
            @(negedge clk);
            if (!pending && sent < 1000 && $urandom_range(0, 3) != 0) begin
                b_x = 16'($urandom); b_y = 16'($urandom); b_exact = 1'($urandom);
                pending = 1'b1;
            end
            b_in_valid  = pending;
            b_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (b_in_valid && b_in_ready) begin
                lx = 64'(b_x);
                ly = 64'(b_y);
                exp_z.push_back(lx * ly);
                exp_e.push_back(b_exact);
                pending = 1'b0;
                sent++;
            end
            if (b_out_valid && b_out_ready) begin
                n_checks++;
                if (exp_z.size() == 0) begin
                    n_fail++; $display("FAIL exact_extra_beat: got z=%0d expected no beat", b_z);
                end else begin
                    if (b_z !== exp_z[0] || b_out_exact !== exp_e[0]) begin
                        n_fail++; $display("FAIL exact_result[%0d]: got z=%0d e=%b expected z=%0d e=%b", got, b_z, b_out_exact, exp_z[0], exp_e[0]);
                    end
                    void'(exp_z.pop_front());
                    void'(exp_e.pop_front());
                end
                got++;
            end
            cyc++;
        end
        b_in_valid = 1'b0;
        b_out_ready = 1'b1;
        n_checks++; if (got !== 1000) begin n_fail++; $display("FAIL exact_count: got %0d expected 1000", got); end
    endtask

    task automatic test_sweep();
        longint unsigned exp_z [$];
        int              sent = 0, got = 0, cyc = 0;
        while (got < 256 && cyc < 2000) begin
            @(negedge clk);
            c_in_valid  = (sent < 256);
            c_x         = 4'(sent >> 4);
            c_y         = 4'(sent);
            c_exact     = 1'b0;
            c_out_ready = ($urandom_range(0, 4) != 0);
            #1;
            if (c_in_valid && c_in_ready) begin
                exp_z.push_back(model(4, 3, 6, 64'(c_x), 64'(c_y), 1'b0));
                sent++;
            end
            if (c_out_valid && c_out_ready) begin
                n_checks++;
                if (exp_z.size() == 0) begin
                    n_fail++; $display("FAIL sweep_extra_beat: got z=%0d expected no beat", c_z);
                end else begin
                    if (c_z !== exp_z[0]) begin
                        n_fail++; $display("FAIL sweep_result[x=%0d y=%0d]: got %0d expected %0d", got >> 4, got & 15, c_z, exp_z[0]);
                    end
                    void'(exp_z.pop_front());
                end
                got++;
            end
            cyc++;
        end
        c_in_valid = 1'b0;
        c_out_ready = 1'b1;
        n_checks++; if (got !== 256) begin n_fail++; $display("FAIL sweep_count: got %0d expected 256", got); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_in_valid = 1'b0; a_x = '0; a_y = '0; a_exact = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_x = '0; b_y = '0; b_exact = 1'b0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_x = '0; c_y = '0; c_exact = 1'b0; c_out_ready = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        test_exact_path();
        test_sweep();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/approx_mul_pipe.md
# approx_mul_pipe

Parametrised, pipelined unsigned approximate multiplier; next generation of the fixed 8x8 two-row exchange multipliers. The low `L` rows of the partial-product array are truncated below column `K` and OR-compressed at and above it, while the high rows are multiplied exactly. A per-transaction mode bit selects an exact product instead. It sits in datapaths as a streaming operator with valid/ready handshakes on both sides and full backpressure.

## Interface
- `W`, default 8: operand width; legal values 4..32.
- `L`, default 2: number of approximated low rows of `x`; legal values 0..W-1. `L=0` means the approximate path equals the exact path.
- `K`, default 7: lowest kept column of the low rows; legal values 1..W+L-1.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous reset, active-high.
- `in_valid` input 1: operand beat valid.
- `in_ready` output 1: block accepts a beat this cycle.
- `in_x` input W: multiplier operand; rows are selected by its bits.
- `in_y` input W: multiplicand operand.
- `in_exact` input 1: 1 selects the exact product for this beat.
- `out_valid` output 1: result beat valid.
- `out_ready` input 1: downstream accepts the result.
- `out_z` output 2W: product.
- `out_exact` output 1: echo of `in_exact` for this beat.

## Operation
- Definitions:
  - `pp(i,j) = x[i] & y[j]`, with weight 2^(i+j).
  - High part `H = (y * x[W-1:L]) << L`, computed exactly at full 2W width.
  - For each column c ≥ K: `o_c` is the OR of `pp(i, c-i)` over i in 0..L-1 with 0 ≤ c-i ≤ W-1.
  - Compensation bit `p` is the OR of `pp(i, K-1-i)` over the same index rules.
- Approximate result: `z = H + Σ(o_c · 2^c) + (p · 2^K)`, modulo 2^2W. The final sum cannot overflow for legal parameters.
- Exact result: `z = x * y` at full width.
- Beats leave in the order they arrived. No reordering and no drop except on reset.

## Timing
- Three register stages:
  - S1 captures operands and the mode bit.
  - S2 holds `H`, the `o` vector and `p`, or the exact product when `in_exact=1`.
  - S3 holds the final sum.
- Latency is 3 cycles from handshake (`in_valid & in_ready`) to `out_valid`, with no stalls.
- Throughput is 1 beat/cycle when `out_ready=1`.
- Stall rule: `adv = !(s3_valid & !out_ready)`.
  - All stages shift only when `adv=1`.
  - `in_ready = adv`. This is combinational from `out_ready`.
- Bubbles are not collapsed. A stalled pipeline holds all stage contents unchanged.
- While `out_valid=1` and `out_ready=0`, `out_z` and `out_exact` hold stable.
- Once asserted, `out_valid` stays high until the beat is accepted.
- `in_valid` dropping while `in_ready=0` is legal; no beat is taken.
- Reset state:
  - All stage valids are 0, so `out_valid=0`.
  - `out_z=0` and `out_exact=0`.
  - `in_ready=1`.
- Reset asserted mid-stream discards all in-flight beats. The first beat accepted after deassertion emerges 3 cycles later.
- Data registers need no reset apart from the output registers.

## Configuration
- Macro `APPROX_MUL_COMP_EN`:
  - Defined: the compensation bit `p` is added at weight 2^K, as specified above.
  - Undefined: `p` is neither generated nor added, so `z = H + Σ o_c · 2^c`.
- Exact mode is unaffected by the macro.

## Structure
- Package `approx_mul_pkg`:
  - localparam function `zw(W)` returning 2W.
  - Parameter legality check function for `(W, L, K)`, called from an initial assertion.
  - Stage payload struct typedef: `x`, `y`, `exact`, partial sums.
- One sub-module, `approx_pp_compress`, combinational and parametrised by `W`, `L`, `K`:
  - Inputs: `x[L-1:0]` and `y`.
  - Outputs: the column OR vector `o` (2W wide, zero below K) and `p`.
  - Instantiated in the S1→S2 logic.

## Test plan
- W=8, L=2, K=7, macro defined; x=0xFF, y=0xFF, approx → z=64772 after 3 cycles. Macro undefined → 64644. Exact mode → 65025.
- x=0x03, y=0x80, approx → z=384, equal to exact. x=0x03, y=0x01, approx → z=0, against exact 3.
- Back-to-back stream of 16 beats with `out_ready` toggling 1,0,0,1 → all 16 results in order, each stable while stalled, `in_ready` low exactly on stall cycles.
- Reset pulse with 3 beats in flight → `out_valid` low within the reset cycle, no stale beat afterwards, next beat's latency 3.
- L=0, W=16, random 1000 beats with mixed mode → every `out_z` equals `x*y`.
- W=4, L=3, K=6 sweep of all 256 operand pairs → matches the golden model formula bit-exactly for both macro settings.
